spi_calc_sequencer: RTL and testbench

- Frame-level controller between the SPI byte slave and the 8-bit adder datapath, in the system clock domain.
- Parses each chip-select frame: command byte, then operand bytes X and Y.
- Drives the adder operands, captures the sum and carry, and hands one response byte to the SPI slave transmit side.
- Flags result validity for the board LED.

---
 rtl/spi_calc_pkg.sv | 19 +
 rtl/spi_calc_timeout.sv | 31 +++
 rtl/spi_calc_sequencer.sv | 117 +++++++++++
 tb/tb_spi_calc_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_calc_pkg.sv
// Shared types and constants for the SPI calculator frame sequencer.
package spi_calc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_X   = 3'd1,
    GET_Y   = 3'd2,
    EXEC    = 3'd3,
    LOAD_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0] CMD_ADD  = 8'hA1;
  localparam logic [7:0] CMD_READ = 8'hA2;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/spi_calc_timeout.sv
// Inter-byte watchdog for the operand-collection states (built only with SPI_CALC_TIMEOUT_EN).
module spi_calc_timeout
  import spi_calc_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count;

  // Idle states also clear, so every operand wait starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/spi_calc_sequencer.sv
// Frame parser between the SPI byte slave and the 8-bit adder.
// Optional inter-byte timeout enabled by defining SPI_CALC_TIMEOUT_EN.
module spi_calc_sequencer
  import spi_calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_load,
  output logic [7:0] tx_data,
  output logic [7:0] calc_x,
  output logic [7:0] calc_y,
  input  logic [7:0] calc_sum,
  input  logic       calc_carry,
  output logic       result_valid,
  output logic       carry_flag,
  output logic       overrun
);

  state_t     state;
  logic [7:0] result_q;
  logic [7:0] response;
  logic       timeout_hit;

`ifdef SPI_CALC_TIMEOUT_EN
  spi_calc_timeout u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_valid),
    .run     ((state == GET_X) || (state == GET_Y)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: state and datapath registers use <= so every branch sees pre-edge values;
  // all of them are reset, including the stored result, since the LED and READ depend on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      result_q     <= '0;
      response     <= '0;
      tx_load      <= 1'b0;
      tx_data      <= '0;
      calc_x       <= '0;
      calc_y       <= '0;
      result_valid <= 1'b0;
      carry_flag   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      // Chip-select release beats any byte arriving in the same cycle.
      if (state != IDLE && !frame_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid && frame_active) begin
              case (rx_data)
                CMD_ADD:  state <= GET_X;
                CMD_READ: begin
                  response <= result_q;
                  state    <= LOAD_TX;
                end
                default: begin
                  response <= ERR_BYTE;
                  state    <= LOAD_TX;
                end
              endcase
            end
          end
          GET_X: begin
            if (rx_valid) begin
              calc_x <= rx_data;
              state  <= GET_Y;
            end else if (timeout_hit) begin
              response <= ERR_BYTE;
              state    <= LOAD_TX;
            end
          end
          GET_Y: begin
            if (rx_valid) begin
              calc_y <= rx_data;
              state  <= EXEC;
            end else if (timeout_hit) begin
              response <= ERR_BYTE;
              state    <= LOAD_TX;
            end
          end
          EXEC: begin
            result_q     <= calc_sum;
            carry_flag   <= calc_carry;
            result_valid <= 1'b1;
            response     <= calc_sum;
            state        <= LOAD_TX;
            if (rx_valid) overrun <= 1'b1;
          end
          LOAD_TX: begin
            if (rx_valid) overrun <= 1'b1;
            if (!tx_busy) begin
              tx_load <= 1'b1;
              tx_data <= response;
              state   <= DONE;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_calc_sequencer.sv
// Directed self-checking bench for spi_calc_sequencer; the adder is modelled here.
module tb_spi_calc_sequencer;
  import spi_calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_active = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_busy = 1'b0;
  logic       tx_load;
  logic [7:0] tx_data;
  logic [7:0] calc_x, calc_y, calc_sum;
  logic       calc_carry;
  logic       result_valid, carry_flag, overrun;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int snap;
  logic got;

  always #5 clk = ~clk;

  assign {calc_carry, calc_sum} = {1'b0, calc_x} + {1'b0, calc_y};

  always @(negedge clk) if (tx_load) load_cnt++;

  spi_calc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_busy      (tx_busy),
    .tx_load      (tx_load),
    .tx_data      (tx_data),
    .calc_x       (calc_x),
    .calc_y       (calc_y),
    .calc_sum     (calc_sum),
    .calc_carry   (calc_carry),
    .result_valid (result_valid),
    .carry_flag   (carry_flag),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_load(input int max_cyc, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (tx_load) seen = 1'b1;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_active = 1'b1;
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame_active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_tx_load", 32'(tx_load), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;

    // Frame A1,12,34: exact two-cycle latency after the Y byte.
    snap = load_cnt;
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h12);
    send_byte(8'h34);
    check("add_no_load_exec", 32'(tx_load), 0);
    @(negedge clk);
    check("add_no_load_ltx", 32'(tx_load), 0);
    @(negedge clk);
    check("add_load_pulse", 32'(tx_load), 1);
    check("add_tx_data", 32'(tx_data), 32'h46);
    check("add_result_valid", 32'(result_valid), 1);
    check("add_carry", 32'(carry_flag), 0);
    // Trailing byte in DONE is ignored without flagging.
    send_byte(8'h55);
    check("done_no_overrun", 32'(overrun), 0);
    check("done_state", 32'(dut.state), 32'(DONE));
    end_frame();
    check("add_single_load", 32'(load_cnt - snap), 1);
    check("tx_data_hold", 32'(tx_data), 32'h46);

    // Frame A1,F0,20: wraps to 10 with carry.
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'hF0);
    send_byte(8'h20);
    wait_load(10, got);
    check("wrap_load_seen", 32'(got), 1);
    check("wrap_tx_data", 32'(tx_data), 32'h10);
    check("wrap_carry", 32'(carry_flag), 1);
    end_frame();

    // READ returns the stored sum, carry untouched.
    start_frame();
    send_byte(CMD_READ);
    @(negedge clk);
    check("read_load_pulse", 32'(tx_load), 1);
    check("read_tx_data", 32'(tx_data), 32'h10);
    check("read_carry", 32'(carry_flag), 1);
    end_frame();

    // Unknown opcode.
    snap = load_cnt;
    start_frame();
    send_byte(8'h5C);
    wait_load(10, got);
    check("err_load_seen", 32'(got), 1);
    check("err_tx_data", 32'(tx_data), 32'hEE);
    end_frame();
    check("err_single_load", 32'(load_cnt - snap), 1);
    check("err_result_valid", 32'(result_valid), 1);
    check("err_carry", 32'(carry_flag), 1);

    // Abort after X: no response, FSM idle, X retained.
    snap = load_cnt;
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h12);
    end_frame();
    check("abort_no_load", 32'(load_cnt - snap), 0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_calc_x", 32'(calc_x), 32'h12);

    // Abort coinciding with the Y byte: byte dropped, no overrun.
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h33);
    @(negedge clk);
    rx_valid     = 1'b1;
    rx_data      = 8'h99;
    frame_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("race_state", 32'(dut.state), 32'(IDLE));
    check("race_calc_y", 32'(calc_y), 32'h20);
    check("race_overrun", 32'(overrun), 0);

    start_frame();
    send_byte(CMD_READ);
    wait_load(10, got);
    check("read2_load_seen", 32'(got), 1);
    check("read2_tx_data", 32'(tx_data), 32'h10);
    end_frame();

    // tx_busy back-pressure with a byte arriving during the wait.
    snap = load_cnt;
    tx_busy = 1'b1;
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = (i == 3);
      rx_data  = 8'h77;
    end
    rx_valid = 1'b0;
    check("busy_no_load", 32'(load_cnt - snap), 0);
    check("busy_overrun", 32'(overrun), 1);
    tx_busy = 1'b0;
    @(negedge clk);
    check("busy_load_pulse", 32'(tx_load), 1);
    check("busy_tx_data", 32'(tx_data), 32'h03);
    end_frame();

    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h07);
`ifdef SPI_CALC_TIMEOUT_EN
    wait_load(DEF_TIMEOUT_CYC + 20, got);
    check("tmo_load_seen", 32'(got), 1);
    check("tmo_tx_data", 32'(tx_data), 32'hEE);
    end_frame();
    start_frame();
    send_byte(CMD_READ);
    wait_load(10, got);
    check("tmo_read_data", 32'(tx_data), 32'h03);
`else
    repeat (1100) @(negedge clk);
    check("stall_state", 32'(dut.state), 32'(GET_Y));
    send_byte(8'h09);
    wait_load(10, got);
    check("stall_load_seen", 32'(got), 1);
    check("stall_tx_data", 32'(tx_data), 32'h10);
    check("stall_carry", 32'(carry_flag), 0);
`endif
    end_frame();

    // Reset asserted mid-frame.
    start_frame();
    send_byte(CMD_ADD);
    send_byte(8'h33);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_state", 32'(dut.state), 32'(IDLE));
    check("mrst_tx_load", 32'(tx_load), 0);
    check("mrst_tx_data", 32'(tx_data), 0);
    check("mrst_calc_x", 32'(calc_x), 0);
    check("mrst_result_valid", 32'(result_valid), 0);
    check("mrst_overrun", 32'(overrun), 0);
    check("mrst_carry", 32'(carry_flag), 0);
    frame_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
